// File: rtl/sobel_kernel.sv
// 3x3 Sobel gradient kernel: column-shift window, weighted row/column sums,
// then signed differences; 3-edge latency from window-valid capture to output.
module sobel_kernel #(
  parameter int PIXEL_WIDTH = 8,
  parameter int SOBEL_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          win_valid,
  input  logic                          line_start,
  input  logic [PIXEL_WIDTH-1:0]        row_top,
  input  logic [PIXEL_WIDTH-1:0]        row_mid,
  input  logic [PIXEL_WIDTH-1:0]        row_bot,
  output logic                          sobel_valid,
  output logic signed [SOBEL_WIDTH-1:0] gx_out,
  output logic signed [SOBEL_WIDTH-1:0] gy_out
);
  localparam int SW     = PIXEL_WIDTH + 2;
  localparam int STAGES = 3;

  // Index 0 = left column, 1 = mid, 2 = right.
  logic [2:0][PIXEL_WIDTH-1:0] r_top, r_mid, r_bot;
  logic [1:0]                  r_cnt, w_cnt_nxt;
  logic                        w_win_ok;
  logic [STAGES-1:0]           r_vld_pipe;
  logic [SW-1:0]               r_sum_l, r_sum_r, r_sum_t, r_sum_b;
  logic signed [SOBEL_WIDTH-1:0] r_gx, r_gy;

  function automatic logic [SW-1:0] wsum(input logic [PIXEL_WIDTH-1:0] a,
                                         input logic [PIXEL_WIDTH-1:0] b,
                                         input logic [PIXEL_WIDTH-1:0] c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (win_valid) begin
      if (line_start)         w_cnt_nxt = 2'd1;
      else if (r_cnt != 2'd3) w_cnt_nxt = r_cnt + 2'd1;
    end
    w_win_ok = win_valid && (w_cnt_nxt == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top <= '0;
      r_mid <= '0;
      r_bot <= '0;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (win_valid) begin
        r_top <= {row_top, r_top[2], r_top[1]};
        r_mid <= {row_mid, r_mid[2], r_mid[1]};
        r_bot <= {row_bot, r_bot[2], r_bot[1]};
      end
    end
  end

  // Data stages run every cycle; only the valid shift register decides what is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_sum_l     <= '0;
      r_sum_r     <= '0;
      r_sum_t     <= '0;
      r_sum_b     <= '0;
      r_gx        <= '0;
      r_gy        <= '0;
      sobel_valid <= 1'b0;
      gx_out      <= '0;
      gy_out      <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[STAGES-2:0], w_win_ok};
      r_sum_l     <= wsum(r_top[0], r_mid[0], r_bot[0]);
      r_sum_r     <= wsum(r_top[2], r_mid[2], r_bot[2]);
      r_sum_t     <= wsum(r_top[0], r_top[1], r_top[2]);
      r_sum_b     <= wsum(r_bot[0], r_bot[1], r_bot[2]);
      r_gx        <= SOBEL_WIDTH'(r_sum_r) - SOBEL_WIDTH'(r_sum_l);
      r_gy        <= SOBEL_WIDTH'(r_sum_b) - SOBEL_WIDTH'(r_sum_t);
      sobel_valid <= r_vld_pipe[STAGES-1];
      gx_out      <= r_vld_pipe[STAGES-1] ? r_gx : '0;
      gy_out      <= r_vld_pipe[STAGES-1] ? r_gy : '0;
    end
  end
endmodule

// File: tb/tb_sobel_kernel.sv
// Directed bench for sobel_kernel: inputs driven and outputs checked on the
// falling edge; a capture at posedge E is checked four cyc() calls later.
module tb_sobel_kernel;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              win_valid = 1'b0;
  logic              line_start = 1'b0;
  logic [7:0]        row_top = '0, row_mid = '0, row_bot = '0;
  logic              sobel_valid;
  logic signed [10:0] gx_out, gy_out;
  int checks = 0;
  int failures = 0;

  sobel_kernel #(.PIXEL_WIDTH(8), .SOBEL_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .line_start(line_start),
    .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .sobel_valid(sobel_valid), .gx_out(gx_out), .gy_out(gy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ev,
                     input logic signed [10:0] egx, input logic signed [10:0] egy);
    checks++;
    assert (sobel_valid === ev) else begin
      failures++;
      $error("FAIL %s sobel_valid got=%0b exp=%0b", tag, sobel_valid, ev);
    end
    checks++;
    assert (gx_out === egx) else begin
      failures++;
      $error("FAIL %s gx got=%0d exp=%0d", tag, gx_out, egx);
    end
    checks++;
    assert (gy_out === egy) else begin
      failures++;
      $error("FAIL %s gy got=%0d exp=%0d", tag, gy_out, egy);
    end
  endtask

  // Check the outputs expected at this falling edge, then drive the next column.
  task automatic cyc(input string tag, input logic v, input logic ls,
                     input logic [7:0] t, input logic [7:0] m, input logic [7:0] b,
                     input logic ev, input logic signed [10:0] egx,
                     input logic signed [10:0] egy);
    @(negedge clk);
    chk(tag, ev, egx, egy);
    win_valid  = v;
    line_start = ls;
    row_top    = t;
    row_mid    = m;
    row_bot    = b;
  endtask

  task automatic idle(input string tag, input logic ev,
                      input logic signed [10:0] egx, input logic signed [10:0] egy);
    cyc(tag, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, ev, egx, egy);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk("reset_hold", 1'b0, 11'sd0, 11'sd0);
    #15 rst = 1'b0;

    // Uniform 128 field, 8 columns: six zero-gradient outputs.
    cyc("uni0", 1, 1, 128, 128, 128, 0, 0, 0);
    for (int i = 1; i < 6; i++) cyc("uni_pre", 1, 0, 128, 128, 128, 0, 0, 0);
    cyc("uni6", 1, 0, 128, 128, 128, 1, 0, 0);
    cyc("uni7", 1, 0, 128, 128, 128, 1, 0, 0);
    for (int i = 0; i < 4; i++) idle("uni_tail", 1, 0, 0);
    idle("uni_end", 0, 0, 0);

    // Vertical step 0,0,255,255,255.
    cyc("vs0", 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("vs1", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("vs2", 1, 0, 255, 255, 255, 0, 0, 0);
    cyc("vs3", 1, 0, 255, 255, 255, 0, 0, 0);
    cyc("vs4", 1, 0, 255, 255, 255, 0, 0, 0);
    idle("vs_i0", 0, 0, 0);
    idle("vs_out0", 1, 1020, 0);
    idle("vs_out1", 1, 1020, 0);
    idle("vs_out2", 1, 0, 0);
    idle("vs_end", 0, 0, 0);

    // Horizontal step: top=0, mid=0, bot=255.
    cyc("hs0", 1, 1, 0, 0, 255, 0, 0, 0);
    for (int i = 1; i < 4; i++) cyc("hs_n", 1, 0, 0, 0, 255, 0, 0, 0);
    idle("hs_i0", 0, 0, 0);
    idle("hs_i1", 0, 0, 0);
    idle("hs_out0", 1, 0, 1020);
    idle("hs_out1", 1, 0, 1020);
    idle("hs_end", 0, 0, 0);

    // Ramp with two idle cycles between 3rd and 4th captures.
    // top={0,10,30,60,100}, mid=top+20, bot=top+40 -> gx=120,200,280, gy=160.
    cyc("rp0", 1, 1, 0, 20, 40, 0, 0, 0);
    cyc("rp1", 1, 0, 10, 30, 50, 0, 0, 0);
    cyc("rp2", 1, 0, 30, 50, 70, 0, 0, 0);
    cyc("rp_g0", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rp_g1", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rp3", 1, 0, 60, 80, 100, 0, 0, 0);
    cyc("rp4", 1, 0, 100, 120, 140, 1, 120, 160);
    idle("rp_i7", 0, 0, 0);
    idle("rp_i8", 0, 0, 0);
    idle("rp_out1", 1, 200, 160);
    idle("rp_out2", 1, 280, 160);
    idle("rp_end", 0, 0, 0);

    // line_start on column 4: old-line results still drain, new line restarts count.
    cyc("ls_a0", 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("ls_a1", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("ls_a2", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("ls_a3", 1, 0, 255, 255, 255, 0, 0, 0);
    cyc("ls_n0", 1, 1, 255, 255, 255, 0, 0, 0);
    cyc("ls_n1", 1, 0, 255, 255, 255, 0, 0, 0);
    cyc("ls_n2", 1, 0, 0, 0, 0, 1, 0, 0);
    idle("ls_old3", 1, 1020, 0);
    idle("ls_new1", 0, 0, 0);
    idle("ls_new2", 0, 0, 0);
    idle("ls_new3", 1, -1020, 0);
    idle("ls_end", 0, 0, 0);

    // Reset after 5th capture of a line.
    cyc("rs0", 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("rs1", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("rs2", 1, 0, 255, 255, 255, 0, 0, 0);
    cyc("rs3", 1, 0, 255, 255, 255, 0, 0, 0);
    cyc("rs4", 1, 0, 255, 255, 255, 0, 0, 0);
    idle("rs_i5", 0, 0, 0);
    idle("rs_pre", 1, 1020, 0);
    #2 rst = 1'b1;
    #1 chk("rs_async_clear", 0, 0, 0);
    #1 rst = 1'b0;
    // No line_start after reset: captures 1,2 silent, capture 3 (100,50,0) -> gx=-400.
    cyc("pr0", 1, 0, 100, 100, 100, 0, 0, 0);
    cyc("pr1", 1, 0, 50, 50, 50, 0, 0, 0);
    cyc("pr2", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("pr_i3", 0, 0, 0);
    idle("pr_i4", 0, 0, 0);
    idle("pr_i5", 0, 0, 0);
    idle("pr_out", 1, -400, 0);
    idle("pr_end", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
